fft_bfly_scheduler: RTL and testbench
=====================================

Name: fft_bfly_scheduler

Overview:
Sequences an in-place radix-2 decimation-in-time FFT over a dual-port sample RAM using the shared MultiplyAddUnit butterfly. The controller does four things:
- issues one butterfly per cycle within a stage;
- generates read addresses for the A/B operands and the twiddle-ROM index;
- delays the write-back addresses to match the butterfly pipeline;
- drains that pipeline between stages so no stage reads stale data.

Samples enter bit-reversed. Results leave in natural order.

Parameters:
N_LOG2, 3, log2 of FFT size N (N = 8 by default); legal range 2..10.
BFLY_LATENCY, 3, Clk edges from operands valid at MultiplyAddUnit inputs to Y/Z valid.
RAM_LATENCY, 1, Clk edges from rd_en/address to read data valid.

Ports:
Clk  in  1  system clock, all state on rising edge
Rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run a full FFT; ignored while busy
busy  out  1  high from the first issue cycle through the last write-back cycle
done  out  1  one-cycle pulse, the cycle after the final write-back
rd_en  out  1  read strobe for both RAM ports and the twiddle ROM
rd_addr_a  out  N_LOG2  top-wing sample address
rd_addr_b  out  N_LOG2  bottom-wing sample address
tw_addr  out  N_LOG2-1  twiddle index k for W_N^k
wr_en  out  1  write strobe for both RAM ports (Y to addr_a, Z to addr_b)
wr_addr_a  out  N_LOG2  delayed rd_addr_a
wr_addr_b  out  N_LOG2  delayed rd_addr_b
stage  out  clog2(N_LOG2)  current stage index, debug/status

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the write-delay pipeline valid bits are cleared. Rst mid-run aborts immediately: no further wr_en, and no done.
- WB_DELAY is RAM_LATENCY + BFLY_LATENCY. A butterfly issued (rd_en) in cycle t has wr_en and its write addresses in cycle t+WB_DELAY.
- State IDLE: on start=1, go to ISSUE with stage=0 and k=0.
- State ISSUE: rd_en=1 every cycle.
  - Addressing for stage s, butterfly k in 0..N/2-1: half = 1<<s; pos = k & (half-1); grp = k >> s.
  - rd_addr_a = grp*2*half + pos; rd_addr_b = rd_addr_a + half; tw_addr = pos << (N_LOG2-1-s).
  - k increments each cycle. After k = N/2-1, go to DRAIN.
- State DRAIN: rd_en=0 for exactly WB_DELAY cycles (counter). Then:
  - if stage < N_LOG2-1, increment stage, clear k, go to ISSUE;
  - otherwise go to DONE.
- DRAIN length guarantees the first read of stage s+1 occurs one cycle after the last write of stage s. The RAM is not required to be write-through.
- State DONE: done=1 for one cycle, busy=0, then go to IDLE.
- The write-delay pipeline is a WB_DELAY-deep shift register of {valid, addr_a, addr_b}, shifted every cycle. wr_en is the valid bit of the last entry.
- busy = (state==ISSUE) | (state==DRAIN).
- start asserted in the same cycle as done, or while busy, is ignored. A new run needs start while IDLE.
- Total run length is N_LOG2*(N/2 + WB_DELAY) cycles of busy.
- tw_addr is always 0 in stage 0.
- All address arithmetic is unsigned and exact within N_LOG2 bits; no wrap occurs for legal k.

Decomposition:
- Package fft_pkg:
  - state enum IDLE/ISSUE/DRAIN/DONE;
  - the packed complex sample format (32-bit word: [31:16] real, [15:0] imag, signed Q5.10);
  - a localparam function computing WB_DELAY.
- Sub-module fft_addr_delay: the parameterised {valid, addr_a, addr_b} shift register. It is reused later for the in-place I/O loader.

Test Plan:
- Default params, start pulsed and sampled at edge 0:
  - rd_en cycles 1-4, pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0;
  - wr_en cycles 5-8 with the same pairs.
- Stage 1:
  - issue cycles 9-12, pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
- Stage 2 and completion:
  - issue cycles 17-20, pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3;
  - wr_en cycles 21-24;
  - done high in cycle 25 only;
  - busy high in cycles 1-24.
- Hazard check: in every cycle, no rd_addr_a/rd_addr_b equals an outstanding (valid, unwritten) write-pipeline address. The scoreboard asserts this across the full run.
- start pulsed in cycle 10 and again in the done cycle: no effect. After returning to IDLE, a second start reproduces an identical 24-cycle trace.
- Rst asserted in cycle 14, async mid-cycle, held 2 cycles:
  - all outputs 0 immediately, and no wr_en or done afterwards;
  - a subsequent start runs cleanly from stage 0.
- End-to-end with MultiplyAddUnit, behavioural RAM and Q5.10 twiddle ROM: bit-reversed impulse x[0]=1.0 (0x0400_0000) gives all eight outputs 0x0400_0000 within ±1 LSB.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT datapath and its controllers.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_state_e;

    // Complex sample word: [31:16] real, [15:0] imag, both signed Q5.10.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    function automatic int wb_delay(input int ram_latency, input int bfly_latency);
        return ram_latency + bfly_latency;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from issue to write-back.
module fft_addr_delay #(
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr_a,
    input  logic [AW-1:0] issue_addr_b,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr_a,
    output logic [AW-1:0] wb_addr_b
);

    logic [2*AW:0] pipe [DEPTH];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {issue_valid, issue_addr_a, issue_addr_b};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {wb_valid, wb_addr_a, wb_addr_b} = pipe[DEPTH-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// In-place radix-2 DIT butterfly scheduler: one butterfly per cycle, pipeline drained between stages.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | one butterfly read per cycle, k = 0..N/2-1
//   DRAIN | WB_DELAY quiet cycles so the stage's writes land before the next stage reads
//   DONE  | one-cycle done pulse
module fft_bfly_scheduler
    import fft_pkg::*;
#(
    parameter int N_LOG2       = 3,
    parameter int BFLY_LATENCY = 3,
    parameter int RAM_LATENCY  = 1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [N_LOG2-1:0]           rd_addr_a,
    output logic [N_LOG2-1:0]           rd_addr_b,
    output logic [N_LOG2-2:0]           tw_addr,
    output logic                        wr_en,
    output logic [N_LOG2-1:0]           wr_addr_a,
    output logic [N_LOG2-1:0]           wr_addr_b,
    output logic [$clog2(N_LOG2)-1:0]   stage
);

    localparam int SW       = $clog2(N_LOG2);
    localparam int WB_DELAY = wb_delay(RAM_LATENCY, BFLY_LATENCY);
    localparam int CW       = $clog2(WB_DELAY + 1);

    localparam logic [N_LOG2-2:0] K_LAST = '1;
    localparam logic [N_LOG2-2:0] K_ONE  = (N_LOG2-1)'(1);
    localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
    localparam logic [SW-1:0]     S_ONE  = SW'(1);
    localparam logic [CW-1:0]     D_LOAD = CW'(WB_DELAY - 1);
    localparam logic [CW-1:0]     D_ONE  = CW'(1);
    localparam logic [N_LOG2-1:0] A_ONE  = N_LOG2'(1);

    fft_state_e          state, state_nxt;
    logic [N_LOG2-2:0]   k, k_nxt;
    logic [SW-1:0]       stage_nxt;
    logic [CW-1:0]       drain_cnt, drain_cnt_nxt;

    logic [N_LOG2-1:0]   k_ext, half, mask, addr_a, addr_b;
    logic [N_LOG2-2:0]   tw_idx;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            k         <= '0;
            stage     <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            stage     <= stage_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        stage_nxt     = stage;
        drain_cnt_nxt = drain_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    k_nxt     = '0;
                    stage_nxt = '0;
                end
            end
            ISSUE: begin
                k_nxt = k + K_ONE;
                if (k == K_LAST) begin
                    state_nxt     = DRAIN;
                    k_nxt         = '0;
                    drain_cnt_nxt = D_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    if (stage != S_LAST) begin
                        stage_nxt = stage + S_ONE;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt - D_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                stage_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clearing the low s bits of k and shifting them up one place inserts the
    // wing-select bit, giving grp*2*half + pos without a multiplier.
    always_comb begin
        k_ext  = {1'b0, k};
        half   = A_ONE << stage;
        mask   = half - A_ONE;
        addr_a = ((k_ext & ~mask) << 1) | (k_ext & mask);
        addr_b = addr_a | half;
        tw_idx = (k & mask[N_LOG2-2:0]) << (S_LAST - stage);
    end

    assign rd_en     = (state == ISSUE);
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? addr_b : '0;
    assign tw_addr   = rd_en ? tw_idx : '0;

    fft_addr_delay #(
        .DEPTH (WB_DELAY),
        .AW    (N_LOG2)
    ) u_addr_delay (
        .Clk          (Clk),
        .Rst          (Rst),
        .issue_valid  (rd_en),
        .issue_addr_a (rd_addr_a),
        .issue_addr_b (rd_addr_b),
        .wb_valid     (wr_en),
        .wb_addr_a    (wr_addr_a),
        .wb_addr_b    (wr_addr_b)
    );

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench for fft_bfly_scheduler at N=8: cycle trace, start filtering, async abort, end-to-end FFT.
module tb_fft_bfly_scheduler;
    import fft_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       start;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    logic [1:0] stage;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int EA [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    localparam int EB [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    localparam int ET [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    localparam int TW_RE [4] = '{1024,  724,     0, -724};
    localparam int TW_IM [4] = '{   0, -724, -1024, -724};

    localparam logic [31:0] X_SHIFT [8] = '{32'h0400_0000, 32'h02D4_FD2C, 32'h0000_FC00, 32'hFD2C_FD2C,
                                            32'hFC00_0000, 32'hFD2C_02D4, 32'h0000_0400, 32'h02D4_02D4};

    fft_bfly_scheduler dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] raw_bus();
        return {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b, stage};
    endfunction

    function automatic logic [19:0] observed_bus();
        return {busy, done, rd_en,
                rd_en ? rd_addr_a : 3'd0, rd_en ? rd_addr_b : 3'd0, rd_en ? tw_addr : 2'd0,
                wr_en, wr_en ? wr_addr_a : 3'd0, wr_en ? wr_addr_b : 3'd0,
                busy ? stage : 2'd0};
    endfunction

    // Cycle c counts from the first cycle after the edge that samples start.
    function automatic logic [19:0] expected_bus(input int c);
        logic       b, d, re, we;
        logic [2:0] ra, rb, wa, wbb;
        logic [1:0] tw, st;
        int s, k;
        b = 0; d = 0; re = 0; we = 0;
        ra = 0; rb = 0; wa = 0; wbb = 0; tw = 0; st = 0;
        s = (c - 1) / 8;
        k = (c - 1) % 8;
        if (c >= 1 && c <= 24) begin
            b  = 1;
            st = 2'(s);
            if (k < 4) begin
                re = 1; ra = 3'(EA[s][k]); rb = 3'(EB[s][k]); tw = 2'(ET[s][k]);
            end else begin
                we = 1; wa = 3'(EA[s][k-4]); wbb = 3'(EB[s][k-4]);
            end
        end
        d = (c == 25);
        return {b, d, re, ra, rb, tw, we, wa, wbb, st};
    endfunction

    // Behavioural RAM plus butterfly; a read at issue time is safe because the
    // schedule never reads an address with a write still in flight.
    cplx_t      mem [8];
    cplx_t      yq [$];
    cplx_t      zq [$];
    logic       load_go;
    logic [1:0] load_sel;

    function automatic cplx_t init_vec(input logic [1:0] sel, input int i);
        cplx_t v;
        v = '0;
        if (sel == 2'd0 && i == 0) v = 32'h0400_0000;
        if (sel == 2'd1 && i == 4) v = 32'h0400_0000;
        return v;
    endfunction

    function automatic void bfly(input cplx_t a, input cplx_t b, input int k,
                                 output cplx_t y, output cplx_t z);
        int tr, ti;
        tr = (int'(b.re) * TW_RE[k] - int'(b.im) * TW_IM[k]) >>> 10;
        ti = (int'(b.re) * TW_IM[k] + int'(b.im) * TW_RE[k]) >>> 10;
        y.re = 16'(int'(a.re) + tr);
        y.im = 16'(int'(a.im) + ti);
        z.re = 16'(int'(a.re) - tr);
        z.im = 16'(int'(a.im) - ti);
    endfunction

    always @(posedge Clk or posedge Rst) begin
        cplx_t y, z;
        if (Rst) begin
            yq.delete();
            zq.delete();
        end else if (load_go) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_vec(load_sel, i);
        end else begin
            if (wr_en && yq.size() > 0) begin
                mem[wr_addr_a] <= yq.pop_front();
                mem[wr_addr_b] <= zq.pop_front();
            end
            if (rd_en) begin
                bfly(mem[rd_addr_a], mem[rd_addr_b], int'(tw_addr), y, z);
                yq.push_back(y);
                zq.push_back(z);
            end
        end
    end

    task automatic run_trace(input string name, input bit poke_start);
        logic       hv [32];
        logic [2:0] ha [32];
        logic [2:0] hb [32];
        int hazards;
        hazards = 0;
        for (int i = 0; i < 32; i++) begin hv[i] = 0; ha[i] = 0; hb[i] = 0; end
        @(negedge Clk);
        start = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge Clk);
            start = poke_start && (c == 10 || c == 25);
            check_val($sformatf("%s_c%0d", name, c), 32'(observed_bus()), 32'(expected_bus(c)));
            hv[c] = rd_en; ha[c] = rd_addr_a; hb[c] = rd_addr_b;
            if (rd_en) begin
                for (int t = c - 4; t < c; t++) begin
                    if (t >= 1 && hv[t] &&
                        (rd_addr_a == ha[t] || rd_addr_a == hb[t] ||
                         rd_addr_b == ha[t] || rd_addr_b == hb[t]))
                        hazards++;
                end
            end
        end
        start = 1'b0;
        check_val({name, "_hazard"}, 32'(hazards), 32'd0);
    endtask

    task automatic run_abort();
        int bad;
        bad = 0;
        @(negedge Clk);
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge Clk);
            start = 1'b0;
        end
        @(negedge Clk);
        check_val("pre_rst_wr_en", 32'(wr_en), 32'd1);
        Rst = 1'b1;
        #1;
        check_val("rst_mid_outputs", 32'(raw_bus()), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (wr_en || done || busy || rd_en) bad++;
        end
        check_val("rst_quiet", 32'(bad), 32'd0);
    endtask

    task automatic run_fft(input logic [1:0] sel, input string name);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 0;
        @(negedge Clk);
        load_sel = sel;
        load_go  = 1'b1;
        @(negedge Clk);
        load_go = 1'b0;
        start   = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        while (!seen && cyc < 60) begin
            if (done) seen = 1;
            else begin
                @(negedge Clk);
                cyc++;
            end
        end
        check_val({name, "_done"}, 32'(seen), 32'd1);
        @(negedge Clk);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("%s_x%0d", name, i), mem[i],
                      (sel == 2'd0) ? 32'h0400_0000 : X_SHIFT[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst      = 1'b1;
        start    = 1'b0;
        load_go  = 1'b0;
        load_sel = 2'd0;
        repeat (2) @(negedge Clk);
        check_val("reset_outputs", 32'(raw_bus()), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        run_trace("run1", 1'b1);
        run_trace("run2", 1'b0);
        run_abort();
        run_trace("after_rst", 1'b0);
        run_fft(2'd0, "impulse0");
        run_fft(2'd1, "impulse1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
